// File: rtl/riscv_pkg.sv
// Shared RV32I types, opcode/ALU encodings and pipeline-register layouts
// used by the decode stage and its helper blocks.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int ILEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  // All-zero encodes a bubble: no register write, no memory access.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    use_pc;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_signals_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
    logic            valid_if_id;
  } if_id_reg_t;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           rs1_data;
    logic [XLEN-1:0]           rs2_data;
    logic [XLEN-1:0]           immediate;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3_for_branch;
    ctrl_signals_t             ctrl;
    logic                      valid_id_ex;
  } id_ex_reg_t;

  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3,
                                                input logic       funct7_b5,
                                                input logic       is_reg_op);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg_op && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decoder.sv
// Opcode/funct decoder producing the control bundle for the EX stage.
// Unknown opcodes decode to an all-zero (bubble-like) control word.
module decoder
  import riscv_pkg::*;
(
  input  logic [6:0]    i_opcode,
  input  logic [2:0]    i_funct3,
  input  logic          i_funct7_b5,
  output ctrl_signals_t o_ctrl
);

  opcode_e w_opcode;
  assign w_opcode = opcode_e'(i_opcode);

  always_comb begin
    o_ctrl = '0;
    case (w_opcode)
      OPC_LUI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.use_pc    = 1'b1;
      end
      OPC_JAL: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.use_pc    = 1'b1;
      end
      OPC_JALR: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OPC_OP_IMM: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = alu_op_from_funct(i_funct3, i_funct7_b5, 1'b0);
      end
      OPC_OP: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = alu_op_from_funct(i_funct3, i_funct7_b5, 1'b1);
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the I/S/B/U/J formats;
// R-type and unknown opcodes yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [ILEN-1:0] i_instr,
  output logic [XLEN-1:0] o_imm
);

  opcode_e w_opcode;
  assign w_opcode = opcode_e'(i_instr[6:0]);

  always_comb begin
    o_imm = '0;
    case (w_opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        o_imm = {i_instr[31:12], 12'b0};
      OPC_JAL:
        o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/load_use_detect.sv
// Flags a load in the ID/EX register whose destination matches either source
// field of the instruction now in ID. rs2 is compared for every format.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
  input  logic                      i_if_valid,
  input  logic                      i_ex_valid,
  input  logic                      i_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
  output logic                      o_hazard
);

  logic w_rd_match;

  assign w_rd_match = (i_ex_rd != '0) && ((i_ex_rd == i_rs1) || (i_ex_rd == i_rs2));
  assign o_hazard   = i_if_valid && i_ex_valid && i_ex_mem_read && w_rd_match;

endmodule

// File: rtl/regfile.sv
// 32-entry integer register file: synchronous write, combinational read,
// x0 hard-wired to zero, contents cleared by reset.
module regfile
  import riscv_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
  output logic [XLEN-1:0]           o_rs1_data,
  output logic [XLEN-1:0]           o_rs2_data,
  input  logic                      i_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [XLEN-1:0]           i_wr_data
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Operands are needed in the decode cycle itself, so the read stays asynchronous.
  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage between IF/ID and EX: backpressure, redirect flush,
// load-use bubble insertion, optional WB->ID bypass and a saturating stall count.
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int WB_BYPASS = 1,
  parameter int HAZARD_EN = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  if_id_reg_t                if_id_in,
  output logic                      id_ready,
  input  logic                      ex_ready,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]           wb_wr_data,
  input  logic                      wb_reg_wr,
  output id_ex_reg_t                id_ex_out,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  logic [1:0][REG_ADDR_WIDTH-1:0] w_src_addr;
  logic [1:0][XLEN-1:0]           w_rf_data;
  logic [1:0][XLEN-1:0]           w_src_data;
  logic [REG_ADDR_WIDTH-1:0]      w_rd_addr;
  ctrl_signals_t                  w_ctrl;
  logic [XLEN-1:0]                w_imm;
  logic                           w_raw_hazard;
  logic                           w_hazard;
  id_ex_reg_t                     w_decoded;

  id_ex_reg_t                     r_id_ex;
  logic [CNT_WIDTH-1:0]           r_stall_cnt;

  assign w_src_addr[0] = if_id_in.instruction[19:15];
  assign w_src_addr[1] = if_id_in.instruction[24:20];
  assign w_rd_addr     = if_id_in.instruction[11:7];

  regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_src_addr[0]),
    .i_rs2_addr (w_src_addr[1]),
    .o_rs1_data (w_rf_data[0]),
    .o_rs2_data (w_rf_data[1]),
    .i_wr_en    (wb_reg_wr),
    .i_wr_addr  (wb_rd_addr),
    .i_wr_data  (wb_wr_data)
  );

  // The regfile write lands at the same edge as this decode, so forward it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    if (WB_BYPASS != 0) begin : g_bypass
      assign w_src_data[gi] = (wb_reg_wr && (wb_rd_addr != '0) && (wb_rd_addr == w_src_addr[gi]))
                              ? wb_wr_data : w_rf_data[gi];
    end else begin : g_direct
      assign w_src_data[gi] = w_rf_data[gi];
    end
  end

  decoder u_decoder (
    .i_opcode    (if_id_in.instruction[6:0]),
    .i_funct3    (if_id_in.instruction[14:12]),
    .i_funct7_b5 (if_id_in.instruction[30]),
    .o_ctrl      (w_ctrl)
  );

  imm_gen u_imm_gen (
    .i_instr (if_id_in.instruction),
    .o_imm   (w_imm)
  );

  load_use_detect u_load_use_detect (
    .i_rs1         (w_src_addr[0]),
    .i_rs2         (w_src_addr[1]),
    .i_if_valid    (if_id_in.valid_if_id),
    .i_ex_valid    (r_id_ex.valid_id_ex),
    .i_ex_mem_read (r_id_ex.ctrl.mem_read),
    .i_ex_rd       (r_id_ex.rd_addr),
    .o_hazard      (w_raw_hazard)
  );

  assign w_hazard = (HAZARD_EN != 0) ? w_raw_hazard : 1'b0;
  assign id_ready = flush || (ex_ready && !w_hazard);

  always_comb begin
    w_decoded                   = '0;
    w_decoded.pc                = if_id_in.pc;
    w_decoded.rs1_data          = w_src_data[0];
    w_decoded.rs2_data          = w_src_data[1];
    w_decoded.immediate         = w_imm;
    w_decoded.rs1_addr          = w_src_addr[0];
    w_decoded.rs2_addr          = w_src_addr[1];
    w_decoded.rd_addr           = w_rd_addr;
    w_decoded.funct3_for_branch = if_id_in.instruction[14:12];
    w_decoded.ctrl              = w_ctrl;
    w_decoded.valid_id_ex       = if_id_in.valid_if_id;
  end

  // Flush outranks hazard and backpressure; a stalled EX freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_ex     <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_id_ex.valid_id_ex <= 1'b0;
    end else if (ex_ready && w_hazard) begin
      r_id_ex.valid_id_ex <= 1'b0;
      r_id_ex.ctrl        <= '0;
      if (r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else if (ex_ready) begin
      r_id_ex <= w_decoded;
    end
  end

  assign id_ex_out = r_id_ex;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by random
// traffic, all checked against an instruction-level reference model.
module tb_id_stage_pipe;
  import riscv_pkg::*;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  localparam int K_ADDI = 0;
  localparam int K_LW   = 1;
  localparam int K_ADD  = 2;
  localparam int K_SW   = 3;
  localparam int K_BEQ  = 4;
  localparam int K_LUI  = 5;
  localparam int K_JAL  = 6;

  typedef enum int {CHK_FULL, CHK_BUBBLE, CHK_VALID} chk_e;

  logic            clk = 1'b0;
  logic            reset;
  if_id_reg_t      if_id_in;
  logic            id_ready;
  logic            ex_ready;
  logic            flush;
  logic [4:0]      wb_rd_addr;
  logic [31:0]     wb_wr_data;
  logic            wb_reg_wr;
  id_ex_reg_t      id_ex_out;
  logic [CW-1:0]   stall_cnt;

  always #5 clk = ~clk;

  id_stage_pipe #(.WB_BYPASS(1), .HAZARD_EN(1), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_id_in   (if_id_in),
    .id_ready   (id_ready),
    .ex_ready   (ex_ready),
    .flush      (flush),
    .wb_rd_addr (wb_rd_addr),
    .wb_wr_data (wb_wr_data),
    .wb_reg_wr  (wb_reg_wr),
    .id_ex_out  (id_ex_out),
    .stall_cnt  (stall_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: architectural registers plus the expected ID/EX contents.
  logic [31:0] m_rf [32];
  chk_e        m_chk;
  logic        m_valid, m_memrd, m_regwr;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  int          m_cnt;
  logic        in_memrd, in_regwr;
  logic [31:0] in_imm;
  logic        obs_ready, exp_ready;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic logic [31:0] encode(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] ins;
    case (kind)
      K_ADDI:  ins = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      K_LW:    ins = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      K_ADD:   ins = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_SW:    ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_BEQ:   ins = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      K_LUI:   ins = {imm[31:12], rd, 7'b0110111};
      default: ins = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endcase
    return ins;
  endfunction

  function automatic logic [31:0] rand_imm(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      K_ADDI, K_LW, K_SW: return {{20{r[11]}}, r[11:0]};
      K_BEQ:              return {{19{r[12]}}, r[12:1], 1'b0};
      K_LUI:              return {r[31:12], 12'b0};
      K_JAL:              return {{11{r[20]}}, r[20:1], 1'b0};
      default:            return 32'd0;
    endcase
  endfunction

  task automatic present(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic v);
    if_id_in.instruction = encode(kind, rd, rs1, rs2, imm);
    if_id_in.pc          = pc_ctr;
    if_id_in.valid_if_id = v;
    pc_ctr               = pc_ctr + 32'd4;
    in_imm               = imm;
    in_memrd             = (kind == K_LW);
    in_regwr             = (kind == K_ADDI) || (kind == K_LW) || (kind == K_ADD) ||
                           (kind == K_LUI)  || (kind == K_JAL);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_reg_wr && (wb_rd_addr == a)) return wb_wr_data;
    return m_rf[a];
  endfunction

  task automatic cycle();
    logic [31:0] ins;
    logic [4:0]  s1, s2;
    logic        hz;
    @(negedge clk);
    ins = if_id_in.instruction;
    s1  = ins[19:15];
    s2  = ins[24:20];
    hz  = if_id_in.valid_if_id && m_valid && m_memrd && (m_rd != 5'd0) && ((m_rd == s1) || (m_rd == s2));
    exp_ready = flush || (ex_ready && !hz);
    obs_ready = id_ready;
    check_eq("id_ready", {31'd0, id_ready}, {31'd0, exp_ready});
    if (reset) begin
      {m_valid, m_memrd, m_regwr} = '0;
      {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
      {m_rs1, m_rs2, m_rd, m_f3} = '0;
      m_cnt = 0;
      m_chk = CHK_FULL;
    end else if (flush) begin
      m_valid = 1'b0;
      m_chk   = CHK_VALID;
    end else if (ex_ready && hz) begin
      m_valid = 1'b0;
      m_memrd = 1'b0;
      m_regwr = 1'b0;
      m_chk   = CHK_BUBBLE;
      if (m_cnt < MAXC) m_cnt++;
    end else if (ex_ready) begin
      m_valid = if_id_in.valid_if_id;
      m_memrd = in_memrd;
      m_regwr = in_regwr;
      m_pc    = if_id_in.pc;
      m_rs1   = s1;
      m_rs2   = s2;
      m_rd    = ins[11:7];
      m_f3    = ins[14:12];
      m_rs1d  = m_read(s1);
      m_rs2d  = m_read(s2);
      m_imm   = in_imm;
      m_chk   = CHK_FULL;
    end
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (wb_reg_wr && (wb_rd_addr != 5'd0)) begin
      m_rf[wb_rd_addr] = wb_wr_data;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("valid_id_ex", {31'd0, id_ex_out.valid_id_ex}, {31'd0, m_valid});
    check_eq("stall_cnt", {30'd0, stall_cnt}, m_cnt);
    if (m_chk != CHK_VALID) begin
      check_eq("mem_read", {31'd0, id_ex_out.ctrl.mem_read}, {31'd0, m_memrd});
      check_eq("reg_write", {31'd0, id_ex_out.ctrl.reg_write}, {31'd0, m_regwr});
    end
    if (m_chk == CHK_FULL) begin
      check_eq("pc", id_ex_out.pc, m_pc);
      check_eq("rs1_addr", {27'd0, id_ex_out.rs1_addr}, {27'd0, m_rs1});
      check_eq("rs2_addr", {27'd0, id_ex_out.rs2_addr}, {27'd0, m_rs2});
      check_eq("rd_addr", {27'd0, id_ex_out.rd_addr}, {27'd0, m_rd});
      check_eq("funct3", {29'd0, id_ex_out.funct3_for_branch}, {29'd0, m_f3});
      check_eq("rs1_data", id_ex_out.rs1_data, m_rs1d);
      check_eq("rs2_data", id_ex_out.rs2_data, m_rs2d);
      check_eq("immediate", id_ex_out.immediate, m_imm);
    end
    $display("[TB] cyc=%0d ins=%h rdy=%0b ex_rdy=%0b flush=%0b rst=%0b -> v=%0b rd=%0d cnt=%0d",
             cyc, ins, obs_ready, ex_ready, flush, reset, id_ex_out.valid_id_ex, id_ex_out.rd_addr, stall_cnt);
  endtask

  task automatic load_then_dependent();
    present(K_LW, 5'd5, 5'd2, 5'd0, 32'd0, 1'b1);
    cycle();
    present(K_ADD, 5'd6, 5'd5, 5'd1, 32'd0, 1'b1);
  endtask

  id_ex_reg_t snap;

  initial begin
    reset = 1'b1; ex_ready = 1'b0; flush = 1'b0;
    wb_reg_wr = 1'b0; wb_rd_addr = '0; wb_wr_data = '0;
    if_id_in = '0;
    in_imm = '0; in_memrd = 1'b0; in_regwr = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    {m_valid, m_memrd, m_regwr} = '0;
    {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_f3} = '0;
    m_cnt = 0; m_chk = CHK_FULL;
    repeat (2) @(posedge clk);
    #1;
    ex_ready = 1'b1;
    present(K_ADDI, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    cycle();
    reset = 1'b0;

    for (int r = 1; r < 8; r++) begin
      wb_reg_wr = 1'b1; wb_rd_addr = 5'(r); wb_wr_data = $urandom;
      cycle();
    end
    wb_reg_wr = 1'b0;

    present(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    cycle();
    check_eq("straight_imm", id_ex_out.immediate, 32'd5);
    check_eq("straight_rd", {27'd0, id_ex_out.rd_addr}, 32'd1);
    check_eq("straight_ready", {31'd0, obs_ready}, 32'd1);

    load_then_dependent();
    cycle();
    check_eq("lu_ready", {31'd0, obs_ready}, 32'd0);
    check_eq("lu_bubble_memrd", {31'd0, id_ex_out.ctrl.mem_read}, 32'd0);
    cycle();
    check_eq("lu_add_rs1", {27'd0, id_ex_out.rs1_addr}, 32'd5);
    check_eq("lu_add_valid", {31'd0, id_ex_out.valid_id_ex}, 32'd1);
    check_eq("lu_cnt", {30'd0, stall_cnt}, 32'd1);

    load_then_dependent();
    ex_ready = 1'b0;
    snap = id_ex_out;
    repeat (3) begin
      cycle();
      check_eq("bp_hold", {31'd0, id_ex_out === snap}, 32'd1);
    end
    check_eq("bp_cnt", {30'd0, stall_cnt}, 32'd1);
    ex_ready = 1'b1;
    cycle();
    check_eq("bp_bubble", {31'd0, id_ex_out.valid_id_ex}, 32'd0);
    cycle();
    check_eq("bp_add_rd", {27'd0, id_ex_out.rd_addr}, 32'd6);

    load_then_dependent();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_eq("flush_ready", {31'd0, obs_ready}, 32'd1);
    check_eq("flush_valid", {31'd0, id_ex_out.valid_id_ex}, 32'd0);
    check_eq("flush_cnt", {30'd0, stall_cnt}, 32'd2);

    present(K_ADDI, 5'd8, 5'd7, 5'd0, 32'd0, 1'b1);
    wb_reg_wr = 1'b1; wb_rd_addr = 5'd7; wb_wr_data = 32'hDEADBEEF;
    cycle();
    check_eq("bypass_rs1", id_ex_out.rs1_data, 32'hDEADBEEF);
    present(K_ADDI, 5'd9, 5'd0, 5'd0, 32'd1, 1'b1);
    wb_rd_addr = 5'd0; wb_wr_data = 32'hFFFFFFFF;
    cycle();
    wb_reg_wr = 1'b0;
    check_eq("x0_rs1", id_ex_out.rs1_data, 32'd0);

    repeat (3) begin
      load_then_dependent();
      cycle();
      cycle();
    end
    check_eq("sat_cnt", {30'd0, stall_cnt}, 32'd3);

    load_then_dependent();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_cnt", {30'd0, stall_cnt}, 32'd0);
    check_eq("rst_valid", {31'd0, id_ex_out.valid_id_ex}, 32'd0);

    for (int n = 0; n < 600; n++) begin
      int kind;
      if (obs_ready) begin
        kind = ($urandom_range(0, 9) < 3) ? K_LW : int'($urandom_range(0, 6));
        present(kind, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                rand_imm(kind), $urandom_range(0, 99) < 85);
      end
      ex_ready   = $urandom_range(0, 9) < 8;
      flush      = $urandom_range(0, 19) == 0;
      reset      = $urandom_range(0, 99) == 0;
      wb_reg_wr  = $urandom_range(0, 1) == 1;
      wb_rd_addr = 5'($urandom_range(0, 7));
      wb_wr_data = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

- Registered, parametrised decode stage.
- Decodes the instruction in `if_id_in` using the existing `regfile`, `decoder` and `imm_gen`, and writes the result into an internal ID/EX pipeline register.
- Adds what the combinational decode path lacks:
  - valid/ready backpressure from EX;
  - flush on redirect;
  - load-use hazard bubble insertion with IF stall;
  - optional WB-to-ID register bypass;
  - a saturating stall counter.
- Sits between the IF/ID register and the EX stage.

## Interface

Parameters:

- `WB_BYPASS`, default 1: when 1, a same-cycle WB write to a source register is forwarded to the read data.
- `HAZARD_EN`, default 1: when 1, load-use detection is active. When 0, `hazard` is tied to 0.
- `CNT_WIDTH`, default 16: width of the stall counter.

Ports:

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `if_id_in`  in  `if_id_reg_t`: pc, instruction, `valid_if_id`.
- `id_ready`  out  1: ID consumes `if_id_in` this cycle. IF must hold when 0.
- `ex_ready`  in  1: EX accepts `id_ex_out` this cycle.
- `flush`  in  1: redirect; kill the instruction in ID and in the output register.
- `wb_rd_addr`  in  `REG_ADDR_WIDTH`: WB destination.
- `wb_wr_data`  in  `XLEN`: WB data.
- `wb_reg_wr`  in  1: WB write enable.
- `id_ex_out`  out  `id_ex_reg_t`: registered decode result, `valid_id_ex` inside.
- `stall_cnt`  out  `CNT_WIDTH`: number of bubble-inserting cycles since reset.

## Operation

**Field extraction** (all from `if_id_in.instruction`):

- rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- `funct3_for_branch` = [14:12].

**Read data:**

- Reads of x0 return 0.
- With `WB_BYPASS`=1: if `wb_reg_wr`, `wb_rd_addr`≠0 and `wb_rd_addr` equals rs1 (or rs2), the read data is `wb_wr_data`.

**Hazard:**

- `hazard` = `if_id_in.valid_if_id` & `id_ex_out.valid_id_ex` & `id_ex_out.ctrl.mem_read` & (`id_ex_out.rd_addr`≠0) & (`id_ex_out.rd_addr`==rs1 | `id_ex_out.rd_addr`==rs2).
- Detection is conservative: rs2 is compared even for formats that do not use it.

**Ready:**

- `id_ready` = `flush` | (`ex_ready` & !`hazard`).

**Register update, priority order, at each rising edge:**

1. `reset`: all `id_ex_out` fields 0; `valid_id_ex`=0; `stall_cnt`=0.
2. `flush`: `valid_id_ex`←0 (other fields don't-care); the ID input is discarded.
3. `ex_ready` & `hazard`: load a bubble (`valid_id_ex`←0, ctrl←0); `stall_cnt`++, saturating at all-ones.
4. `ex_ready`: load the decoded instruction; `valid_id_ex`←`if_id_in.valid_if_id`.
5. Otherwise: hold `id_ex_out` unchanged.

**Bubble fields:**

- A bubble has ctrl all-zero, so `reg_write`=0 and `mem_read`=0.
- A bubble never triggers a further hazard.

**Regfile writes** happen on every edge where `wb_reg_wr` is set, independent of stall or flush.

## Timing

- Latency: 1 cycle from an accepted `if_id_in` to `id_ex_out`.
- `id_ready` and `hazard` are combinational from `if_id_in`, `id_ex_out`, `ex_ready` and `flush`. There is no combinational path from the WB ports to `id_ready`.
- Load-use: exactly one bubble.
  - Cycle N: hazard, bubble loaded, IF held.
  - Cycle N+1: the load has left the output register, so `hazard`=0 and the dependent instruction is loaded.
- While `ex_ready`=0: `id_ex_out` is held stable, `id_ready`=0 and `stall_cnt` does not increment, even if `hazard`=1.
- `flush` together with `hazard` or `ex_ready`=0: flush wins, and the output is invalid next cycle.
- Reset mid-stall: the output is invalid next cycle and the counter clears. Regfile contents follow the `regfile` reset behaviour.
- Saturation: with `stall_cnt`=2^`CNT_WIDTH`−1 and another hazard, the count stays at 2^`CNT_WIDTH`−1.

## Structure

- `riscv_pkg` already holds `if_id_reg_t`, `id_ex_reg_t`, `ctrl_signals_t`, `XLEN` and `REG_ADDR_WIDTH`. `ctrl_signals_t` must contain `mem_read` and `reg_write`. No new types are needed.
- The existing `regfile`, `decoder` and `imm_gen` are instantiated unchanged.
- One new sub-module: `load_use_detect`.
  - Purely combinational.
  - Inputs: rs1, rs2, `if_id_in` valid, `id_ex_out` valid, `id_ex_out.ctrl.mem_read`, `id_ex_out.rd_addr`.
  - Output: `hazard`.

## Test plan

- **Straight line.** `addi x1,x0,5`, valid, `ex_ready`=1 → next cycle `id_ex_out`: immediate=5, rd=1, `valid_id_ex`=1, `id_ready`=1 throughout.
- **Load-use.** `lw x5,0(x2)` followed by `add x6,x5,x1` → after the lw is registered:
  - one cycle with `id_ready`=0 and a bubble output;
  - then the add with rs1=5;
  - `stall_cnt`=1.
- **Backpressure.** Hold `ex_ready`=0 for 3 cycles behind the lw, with the dependent add waiting → `id_ex_out` stable, `stall_cnt` unchanged. On release, one bubble is inserted, then the add.
- **Flush.** `flush`=1 while the output is valid and a hazard is pending → next cycle `valid_id_ex`=0, `id_ready`=1 during the flush, `stall_cnt` unchanged.
- **WB bypass.** `wb_reg_wr`=1, `wb_rd_addr`=7, `wb_wr_data`=0xDEADBEEF in the same cycle as decode of an instruction with rs1=7 → registered `rs1_data`=0xDEADBEEF. With `wb_rd_addr`=0, `rs1_data` for rs1=0 is 0.
- **Saturation and reset.** `CNT_WIDTH`=2, 5 hazards → `stall_cnt`=3. Assert `reset` mid-stall → next cycle `stall_cnt`=0, `valid_id_ex`=0.
